mem_ctrl_ws: RTL and testbench
==============================

// Module: mem_ctrl_ws
// PURPOSE
//  Parametrised successor to the flat 16-bit CPU memory. Single-port RAM with a
//  shared tri-state data bus, programmable wait states, a ready/err completion
//  handshake, and an optional zero-fill sweep after reset. Sits between the CPU
//  bus (address/data/read_write/enable/output_en) and the storage array.
// PARAMETERS
//  DATA_W          16   data bus width (bits)
//  ADDR_W          16   address bus width (bits)
//  DEPTH           4096 words implemented; address >= DEPTH is out of range
//  WAIT_STATES     0    extra cycles inserted before completion (0..15)
//  CLEAR_ON_RESET  1    1: zero-fill all DEPTH words after reset; 0: skip
// PORTS
//  clk         in     1       clock, all state on rising edge
//  reset       in     1       asynchronous, active-low reset
//  address     in     ADDR_W  word address, sampled at accept
//  read_write  in     1       1 = read, 0 = write; sampled at accept
//  enable      in     1       request; held high by requester until ready
//  output_en   in     1       permits driving the data bus
//  data        inout  DATA_W  write data in / read data out (tri-state)
//  ready       out    1       one-cycle completion pulse
//  err         out    1       one-cycle pulse with ready on out-of-range access
//  busy        out    1       high while the clear sweep runs
// BEHAVIOUR
//  - Reset (reset=0): state=CLEAR (IDLE if CLEAR_ON_RESET=0), ready=0, err=0,
//    busy=CLEAR_ON_RESET, rdata_q=0, sweep cnt=0, wait cnt=0; data bus is Z.
//  - CLEAR: write 0 to word cnt each cycle, cnt 0..DEPTH-1; after writing
//    DEPTH-1 go to IDLE, busy falls the same edge. enable is ignored in CLEAR.
//  - IDLE: at an edge with enable=1, latch address/read_write/data into
//    addr_q/rw_q/wdata_q. Go to WAIT (wcnt=WAIT_STATES-1) if WAIT_STATES>0,
//    else go straight to DONE.
//  - WAIT: decrement wcnt; at wcnt=0 go to DONE. Inputs are ignored (latched).
//  - Entering DONE (same edge): a write stores wdata_q at addr_q; a read loads
//    rdata_q from addr_q. Out of range: write dropped, rdata_q=0, err=1.
//  - DONE: ready=1 (err as above) for exactly one cycle, then IDLE
//    unconditionally. The requester drops enable in the ready cycle. enable
//    still high in IDLE counts as a new request.
//  - Latency: ready is high in cycle WAIT_STATES+1 after the accept edge.
//    Throughput: one access per WAIT_STATES+2 cycles.
//  - Bus drive: data = rdata_q when output_en=1 and rw_q=1 and state is IDLE
//    or DONE; otherwise Z. rdata_q holds until the next read completes.
//  - A write never drives the bus. The requester must release the bus whenever
//    output_en=1 with a read pending.
//  - Reset mid-operation: the in-flight access is abandoned with no write, and
//    the sweep reruns when CLEAR_ON_RESET=1.
//  - Range check compares the full ADDR_W address; the array index uses the
//    low $clog2(DEPTH) bits.
// STRUCTURE
//  - mem_defs.vh (shared include): state encodings ST_CLEAR/ST_IDLE/ST_WAIT/
//    ST_DONE (2 bits), RW_READ=1'b1 / RW_WRITE=1'b0.
//  - Sub-module mem_array: DEPTH x DATA_W, one synchronous write port and one
//    combinational read port. mem_ctrl_ws holds the FSM, counters, latches and
//    the tri-state driver.
// TESTING
//  1. Release reset, CLEAR_ON_RESET=1, DEPTH=16 -> busy=1 for 16 cycles, then
//     busy=0; a read of every address returns 16'h0000.
//  2. WAIT_STATES=0: write 16'hBEEF @0x0005, then read 0x0005 with
//     output_en=1 -> ready 1 cycle after each accept; data=16'hBEEF.
//  3. WAIT_STATES=3: read accepted at edge N -> ready and valid data in cycle
//     N+4. Toggling address/enable during WAIT does not change the result.
//  4. DEPTH=16: write 16'h1234 @0x0010, then read 0x0010 -> err=1 with ready
//     both times; read data 0; word 0x0000 is unchanged.
//  5. Hold enable high through ready -> second access accepted in IDLE;
//     exactly 2 ready pulses across 2*(WAIT_STATES+2) cycles.
//  6. Assert reset during WAIT of a write to 0x0003 -> ready never pulses;
//     after the sweep, a read of 0x0003 returns 0. output_en=0 -> data is Z.

Source files
------------

// File: rtl/mem_ctrl_ws_pkg.sv
// mem_ctrl_ws_pkg: shared state encodings and bus direction constants for the wait-state memory controller
package mem_ctrl_ws_pkg;
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;
endpackage

// File: rtl/mem_ctrl_ws_array.sv
// mem_ctrl_ws_array: DEPTH x DATA_W storage, synchronous write, combinational read
module mem_ctrl_ws_array #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4096,
  localparam int AW    = $clog2(DEPTH)
)(
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/mem_ctrl_ws.sv
// mem_ctrl_ws: single-port RAM controller with tri-state data bus, wait states, ready/err handshake and post-reset clear sweep
module mem_ctrl_ws
  import mem_ctrl_ws_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 4096,
  parameter int WAIT_STATES    = 0,
  parameter int CLEAR_ON_RESET = 1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read_write,
  input  logic              enable,
  input  logic              output_en,
  inout  wire  [DATA_W-1:0] data,
  output logic              ready,
  output logic              err,
  output logic              busy
);
  localparam int IDX_W = $clog2(DEPTH);
  state_t r_state, w_next;
  logic [IDX_W-1:0] r_cnt, w_waddr;
  logic [3:0] r_wcnt;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata, w_wdata, w_wmem, w_rd;
  logic r_rw, r_err, w_rw, w_idle, w_clear, w_to_done, w_in_range, w_we;
  assign w_idle  = r_state == ST_IDLE;
  assign w_clear = r_state == ST_CLEAR;
  // With zero wait states the access completes on the accept edge, so the live bus is used
  assign w_addr     = w_idle ? address : r_addr;
  assign w_rw       = w_idle ? read_write : r_rw;
  assign w_wdata    = w_idle ? data : r_wdata;
  assign w_in_range = 32'(w_addr) < DEPTH;
  assign w_to_done  = w_next == ST_DONE;
  assign w_we       = w_clear || (w_to_done && w_rw == RW_WRITE && w_in_range);
  assign w_waddr    = w_clear ? r_cnt : w_addr[IDX_W-1:0];
  assign w_wmem     = w_clear ? '0 : w_wdata;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_CLEAR: w_next = r_cnt == IDX_W'(DEPTH - 1) ? ST_IDLE : ST_CLEAR;
      ST_IDLE:  w_next = !enable ? ST_IDLE : (WAIT_STATES > 0 ? ST_WAIT : ST_DONE);
      ST_WAIT:  w_next = r_wcnt == '0 ? ST_DONE : ST_WAIT;
      default:  w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= CLEAR_ON_RESET != 0 ? ST_CLEAR : ST_IDLE;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_rw    <= RW_WRITE;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_err   <= w_to_done && !w_in_range;
      if (w_clear) r_cnt <= r_cnt + 1'b1;
      if (w_idle && enable) begin
        r_addr  <= address;
        r_rw    <= read_write;
        r_wdata <= data;
        r_wcnt  <= 4'(WAIT_STATES - 1);
      end else if (r_state == ST_WAIT) r_wcnt <= r_wcnt - 1'b1;
      if (w_to_done && w_rw == RW_READ) r_rdata <= w_in_range ? w_rd : '0;
    end
  mem_ctrl_ws_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wmem),
    .i_raddr(w_addr[IDX_W-1:0]),
    .o_rdata(w_rd)
  );
  assign data  = (output_en && r_rw == RW_READ && (w_idle || r_state == ST_DONE)) ? r_rdata : 'z;
  assign ready = r_state == ST_DONE;
  assign err   = r_err;
  assign busy  = w_clear;
endmodule

// File: tb/tb_mem_ctrl_ws.sv
// tb_mem_ctrl_ws: scoreboard bench for mem_ctrl_ws, one instance with 0 and one with 3 wait states, DEPTH=16
module tb_mem_ctrl_ws;
  typedef struct packed {
    logic        rd;
    logic        er;
    logic [15:0] dat;
  } exp_t;
  logic clk;
  logic [1:0] rst_n, rw_s, en, oe, drv_en, rdy, er, bsy;
  logic [15:0] addr [2];
  logic [15:0] drv [2];
  logic [15:0] model [2][16];
  wire  [15:0] data0, data1;
  exp_t q0[$], q1[$];
  int n_chk, n_err;
  int n_ready [2];
  assign data0 = drv_en[0] ? drv[0] : 'z;
  assign data1 = drv_en[1] ? drv[1] : 'z;
  mem_ctrl_ws #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .WAIT_STATES(0), .CLEAR_ON_RESET(1)) u_ws0 (
    .clk(clk), .reset(rst_n[0]), .address(addr[0]), .read_write(rw_s[0]), .enable(en[0]),
    .output_en(oe[0]), .data(data0), .ready(rdy[0]), .err(er[0]), .busy(bsy[0]));
  mem_ctrl_ws #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .WAIT_STATES(3), .CLEAR_ON_RESET(1)) u_ws3 (
    .clk(clk), .reset(rst_n[1]), .address(addr[1]), .read_write(rw_s[1]), .enable(en[1]),
    .output_en(oe[1]), .data(data1), .ready(rdy[1]), .err(er[1]), .busy(bsy[1]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int ws(input int d);
    return d == 0 ? 0 : 3;
  endfunction
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  always @(negedge clk)
    if (rst_n[0] && rdy[0]) begin
      exp_t e;
      n_ready[0]++;
      if (q0.size() == 0) chk("unexpected_ready0", 32'(rdy[0]), 32'd0);
      else begin
        e = q0.pop_front();
        chk("err0", 32'(er[0]), 32'(e.er));
        if (e.rd) chk("rdata0", 32'(data0), 32'(e.dat));
      end
    end
  always @(negedge clk)
    if (rst_n[1] && rdy[1]) begin
      exp_t e;
      n_ready[1]++;
      if (q1.size() == 0) chk("unexpected_ready1", 32'(rdy[1]), 32'd0);
      else begin
        e = q1.pop_front();
        chk("err1", 32'(er[1]), 32'(e.er));
        if (e.rd) chk("rdata1", 32'(data1), 32'(e.dat));
      end
    end
  function automatic exp_t predict(input int d, input logic [15:0] a, input logic rw, input logic [15:0] wd);
    exp_t e;
    e.rd  = rw;
    e.er  = a >= 16;
    e.dat = (rw && a < 16) ? model[d][a[3:0]] : 16'h0;
    if (!rw && a < 16) model[d][a[3:0]] = wd;
    return e;
  endfunction
  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic req(input int d, input logic [15:0] a, input logic rw, input logic [15:0] wd, input bit tog);
    int n;
    push(d, predict(d, a, rw, wd));
    addr[d] = a; rw_s[d] = rw; oe[d] = rw; drv[d] = wd; drv_en[d] = !rw; en[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (tog) begin
        addr[d] = 16'($urandom);
        en[d]   = ~en[d];
      end
    end while (!rdy[d] && n < 20);
    chk("latency", 32'(n), 32'(ws(d) + 1));
    en[d] = 1'b0; drv_en[d] = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    int c0, c1, cnt, n0;
    logic z_ok;
    n_chk = 0; n_err = 0;
    n_ready[0] = 0; n_ready[1] = 0;
    rst_n = 2'b00; rw_s = 2'b11; en = 2'b00; oe = 2'b00; drv_en = 2'b00;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; drv[d] = '0;
      for (int i = 0; i < 16; i++) model[d][i] = 16'h0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bsy), 32'b11);
    chk("rst_ready", 32'(rdy), 32'b00);
    chk("rst_err", 32'(er), 32'b00);
    rst_n = 2'b11;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 40; i++) begin
      c0 += int'(bsy[0]);
      c1 += int'(bsy[1]);
      @(negedge clk);
    end
    chk("clear_len0", 32'(c0), 32'd16);
    chk("clear_len1", 32'(c1), 32'd16);
    for (int a = 0; a < 16; a++) req(0, 16'(a), 1'b1, 16'h0, 1'b0);
    req(1, 16'h000F, 1'b1, 16'h0, 1'b0);
    req(0, 16'h0005, 1'b0, 16'hBEEF, 1'b0);
    req(0, 16'h0005, 1'b1, 16'h0, 1'b0);
    chk("bus_hold", 32'(data0), 32'h0000BEEF);
    oe[0] = 1'b0;
    #1 z_ok = data0 !== 16'hBEEF;
    chk("bus_z", 32'(z_ok), 32'd1);
    req(1, 16'h0007, 1'b0, 16'hCAFE, 1'b1);
    req(1, 16'h0007, 1'b1, 16'h0, 1'b1);
    req(1, 16'h0010, 1'b0, 16'h1234, 1'b0);
    req(1, 16'h0010, 1'b1, 16'h0, 1'b0);
    req(1, 16'h0000, 1'b1, 16'h0, 1'b0);
    req(0, 16'hFFFF, 1'b1, 16'h0, 1'b0);
    for (int d = 0; d < 2; d++) begin
      push(d, predict(d, 16'h0007, 1'b1, 16'h0));
      push(d, predict(d, 16'h0007, 1'b1, 16'h0));
      addr[d] = 16'h0007; rw_s[d] = 1'b1; oe[d] = 1'b1; en[d] = 1'b1;
      cnt = 0;
      for (int i = 0; i < 2 * (ws(d) + 2); i++) begin
        @(negedge clk);
        if (rdy[d]) begin
          cnt++;
          if (cnt == 2) en[d] = 1'b0;
        end
      end
      en[d] = 1'b0;
      chk("b2b_pulses", 32'(cnt), 32'd2);
    end
    n0 = n_ready[1];
    addr[1] = 16'h0003; rw_s[1] = 1'b0; oe[1] = 1'b0; drv[1] = 16'h1111; drv_en[1] = 1'b1; en[1] = 1'b1;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b0; en[1] = 1'b0; drv_en[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_busy", 32'(bsy[1]), 32'd1);
    chk("midrst_ready", 32'(rdy[1]), 32'd0);
    rst_n[1] = 1'b1;
    cnt = 0;
    while (bsy[1] && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    chk("resweep_done", 32'(bsy[1]), 32'd0);
    chk("abort_ready", 32'(n_ready[1] - n0), 32'd0);
    for (int i = 0; i < 16; i++) model[1][i] = 16'h0;
    req(1, 16'h0003, 1'b1, 16'h0, 1'b0);
    req(1, 16'h0007, 1'b1, 16'h0, 1'b0);
    chk("sb_empty0", 32'(q0.size()), 32'd0);
    chk("sb_empty1", 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks, %0d errors", n_chk, n_err);
    $fatal(1, "timeout");
  end
endmodule
